// File: rtl/tlc_pkg.sv
// tlc_pkg: colour codes, fault codes and shared types for the traffic-light monitor.
// TLC_MON_DWELL_CHECK_EN enables dwell-time fault codes 4, 5 and 6.
package tlc_pkg;

   typedef logic [1:0] colour_t;
   typedef logic [2:0] fault_t;

   localparam colour_t RED = 2'b00;
   localparam colour_t YEL = 2'b01;
   localparam colour_t GRN = 2'b10;
   localparam colour_t ILL = 2'b11;

   localparam fault_t F_NONE        = 3'd0;
   localparam fault_t F_ILLEGAL     = 3'd1;
   localparam fault_t F_CONFLICT    = 3'd2;
   localparam fault_t F_BAD_TRANS   = 3'd3;
   localparam fault_t F_SHORT_GREEN = 3'd4;
   localparam fault_t F_BAD_YELLOW  = 3'd5;
   localparam fault_t F_SHORT_WALK  = 3'd6;
   localparam fault_t F_EMERG       = 3'd7;

`ifdef TLC_MON_DWELL_CHECK_EN
   localparam bit DWELL_CHK = 1'b1;
`else
   localparam bit DWELL_CHK = 1'b0;
`endif

endpackage

// File: rtl/tlc_road_tracker.sv
// tlc_road_tracker: previous colour, dwell counter and transition flags
// for one road of the monitored colour bus.
module tlc_road_tracker
   import tlc_pkg::*;
#(
   parameter int MIN_GRN = 5,
   parameter int YEL_LEN = 2,
   parameter int CW      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync,
   input  logic [1:0] col,
   input  logic       other_red,
   input  logic       emerg,
   output logic       illegal,
   output logic       bad_trans,
   output logic       short_green,
   output logic       bad_yellow,
   output logic       red_to_grn
);

   colour_t       prev;
   logic [CW-1:0] dwell;

   // remember the last colour and how many cycles it has been held
   always_ff @(posedge clk) begin
      if (rst) begin
         prev  <= RED;
         dwell <= CW'(1);
      end else if (sync || col != prev) begin
         prev  <= col;
         dwell <= CW'(1);
      end else if (dwell != '1) begin
         dwell <= dwell + CW'(1);
      end
   end

   // classify the step from the previous colour to the current one
   always_comb begin
      illegal     = col == ILL;
      red_to_grn  = prev == RED && col == GRN;
      bad_trans   = (prev == RED && col == YEL) ||
                    (prev == YEL && col == GRN) ||
                    (prev == GRN && col == RED &&
                     !other_red && !emerg);
      short_green = DWELL_CHK && prev == GRN &&
                    col != GRN && dwell < CW'(MIN_GRN);
      bad_yellow  = DWELL_CHK && prev == YEL &&
                    col == RED && dwell != CW'(YEL_LEN);
   end

endmodule

// File: rtl/tlc_light_monitor.sv
// tlc_light_monitor: independent watchdog on the rA/rB colour bus with a
// sticky first-fault capture. TLC_MON_DWELL_CHECK_EN enables dwell checks.
module tlc_light_monitor
   import tlc_pkg::*;
#(
   parameter int MIN_GRN  = 5,
   parameter int YEL_LEN  = 2,
   parameter int WALK_MIN = 4,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    rA,
   input  logic [1:0]    rB,
   input  logic          emergency,
   input  logic          clr_fault,
   output logic          fault,
   output logic [2:0]    fault_code,
   output logic          fault_road,
   output logic [CW-1:0] phase_cnt
);

   typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_FAULT} state_t;

   state_t        state, state_nx;
   logic          sync, all_red, ar_prev, emerg_prev;
   logic [CW-1:0] ar_cnt;
   logic          conflict, emerg_bad, dwell_ok, short_walk;
   logic          ill_a, ill_b, bt_a, bt_b, sg_a, sg_b, by_a, by_b;
   logic          r2g_a, unused_r2g_b;
   logic          viol, cap, clr;
   fault_t        v_code;
   logic          v_road;

   assign sync    = state == ST_SYNC;
   assign all_red = rA == RED && rB == RED;
   assign fault   = state == ST_FAULT;

   tlc_road_tracker #(.MIN_GRN(MIN_GRN), .YEL_LEN(YEL_LEN), .CW(CW)) u_a (
      .clk(clk), .rst(rst), .sync(sync), .col(rA),
      .other_red(rB == RED), .emerg(emergency),
      .illegal(ill_a), .bad_trans(bt_a), .short_green(sg_a),
      .bad_yellow(by_a), .red_to_grn(r2g_a)
   );

   tlc_road_tracker #(.MIN_GRN(MIN_GRN), .YEL_LEN(YEL_LEN), .CW(CW)) u_b (
      .clk(clk), .rst(rst), .sync(sync), .col(rB),
      .other_red(rA == RED), .emerg(emergency),
      .illegal(ill_b), .bad_trans(bt_b), .short_green(sg_b),
      .bad_yellow(by_b), .red_to_grn(unused_r2g_b)
   );

   // all-red run length and the previous emergency sample
   always_ff @(posedge clk) begin
      if (rst) begin
         ar_prev    <= 1'b0;
         ar_cnt     <= CW'(1);
         emerg_prev <= 1'b0;
      end else begin
         emerg_prev <= emergency;
         if (sync || all_red != ar_prev) begin
            ar_prev <= all_red;
            ar_cnt  <= CW'(1);
         end else if (ar_cnt != '1) begin
            ar_cnt <= ar_cnt + CW'(1);
         end
      end
   end

   assign conflict   = rA != RED && rB != RED;
   assign emerg_bad  = !sync && emergency && emerg_prev && !all_red;
   assign dwell_ok   = !sync && !emergency && !emerg_prev;
   assign short_walk = DWELL_CHK && ar_prev && !all_red &&
                       ar_cnt < CW'(WALK_MIN);

   // pick the highest-priority violation this cycle, road A first
   always_comb begin
      v_code = F_NONE;
      v_road = 1'b0;
      if (ill_a) begin
         v_code = F_ILLEGAL;
      end else if (ill_b) begin
         v_code = F_ILLEGAL;
         v_road = 1'b1;
      end else if (conflict) begin
         v_code = F_CONFLICT;
      end else if (emerg_bad) begin
         v_code = F_EMERG;
      end else if (!sync && bt_a) begin
         v_code = F_BAD_TRANS;
      end else if (!sync && bt_b) begin
         v_code = F_BAD_TRANS;
         v_road = 1'b1;
      end else if (dwell_ok && sg_a) begin
         v_code = F_SHORT_GREEN;
      end else if (dwell_ok && sg_b) begin
         v_code = F_SHORT_GREEN;
         v_road = 1'b1;
      end else if (dwell_ok && by_a) begin
         v_code = F_BAD_YELLOW;
      end else if (dwell_ok && by_b) begin
         v_code = F_BAD_YELLOW;
         v_road = 1'b1;
      end else if (dwell_ok && short_walk) begin
         v_code = F_SHORT_WALK;
      end
   end

   assign viol = v_code != F_NONE;

   // next state plus capture/clear strobes for the fault registers
   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      clr      = 1'b0;
      case (state)
         ST_SYNC, ST_RUN: begin
            if (viol) begin
               state_nx = ST_FAULT;
               cap      = 1'b1;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_FAULT: begin
            if (clr_fault) begin
               if (viol) begin
                  cap = 1'b1;
               end else begin
                  state_nx = ST_RUN;
                  clr      = 1'b1;
               end
            end
         end
         default: state_nx = ST_SYNC;
      endcase
   end

   // state, first-fault record and road-A phase counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SYNC;
         fault_code <= F_NONE;
         fault_road <= 1'b0;
         phase_cnt  <= '0;
      end else begin
         state <= state_nx;
         if (cap) begin
            fault_code <= v_code;
            fault_road <= v_road;
         end else if (clr) begin
            fault_code <= F_NONE;
            fault_road <= 1'b0;
         end
         if (!sync && r2g_a) begin
            phase_cnt <= phase_cnt + CW'(1);
         end
      end
   end

endmodule
